// File: rtl/multi_freq_serial_out.sv
// Serial word shifter with four runtime-selectable bit rates, idle-level modes and frame repeat.
// Build option SERIAL_OUT_LSB_FIRST_EN: shift bit 0 first instead of bit DATA_BIT-1.
`timescale 1ns/1ps

module multi_freq_serial_out #(
   parameter int unsigned DATA_BIT     = 16,
   parameter int unsigned TICK_PER_BIT = 16,
   parameter int unsigned DIV_WIDTH    = 16,
   parameter int unsigned DIV0         = 63,
   parameter int unsigned DIV1         = 31,
   parameter int unsigned DIV2         = 15,
   parameter int unsigned DIV3         = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          i_sel_freq,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic [1:0]          i_idle_mode,
   input  logic [DATA_BIT-1:0] i_data,
   output logic                o_data,
   output logic                o_busy,
   output logic                o_done_tick
);

   localparam int unsigned BIT_W  = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
   localparam int unsigned TICK_W = (TICK_PER_BIT > 1) ? $clog2(TICK_PER_BIT) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_BIT-1:0]    word_q, word_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
   logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic                   last_bit_q, last_bit_d;
   logic                   data_q, data_d;
   logic                   busy_q, busy_d;

   logic [DIV_WIDTH-1:0]   sel_div_c;
   logic                   div_tick_c;
   logic                   bit_end_c;
   logic                   frame_end_c;

   // Output bit for a given position in the frame (position 0 goes out first).
   function automatic logic pick_bit(input logic [DATA_BIT-1:0] word, input logic [BIT_W-1:0] pos);
`ifdef SERIAL_OUT_LSB_FIRST_EN
      return word[pos];
`else
      return word[BIT_W'(DATA_BIT - 1) - pos];
`endif
   endfunction

   function automatic logic idle_level(input logic [1:0] mode, input logic last_bit);
      case (mode)
         2'b01:   return 1'b1;
         2'b10:   return last_bit;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      sel_div_c = DIV_WIDTH'(DIV0);
      case (i_sel_freq)
         2'd1:    sel_div_c = DIV_WIDTH'(DIV1);
         2'd2:    sel_div_c = DIV_WIDTH'(DIV2);
         2'd3:    sel_div_c = DIV_WIDTH'(DIV3);
         default: sel_div_c = DIV_WIDTH'(DIV0);
      endcase
   end

   assign div_tick_c  = (div_cnt_q == div_q - DIV_WIDTH'(1));
   assign bit_end_c   = div_tick_c && (tick_cnt_q == TICK_W'(TICK_PER_BIT - 1));
   assign frame_end_c = (state_q == ST_SHIFT) && bit_end_c && (bit_cnt_q == BIT_W'(DATA_BIT - 1));

   // Abort in the frame-end clock suppresses the pulse, so it is qualified by the live stop.
   assign o_done_tick = frame_end_c && !i_stop;
   assign o_data      = data_q;
   assign o_busy      = busy_q;

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      div_d      = div_q;
      div_cnt_d  = div_cnt_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      last_bit_d = last_bit_q;
      data_d     = data_q;

      case (state_q)
         ST_IDLE: begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            data_d     = idle_level(i_idle_mode, last_bit_q);
            if (i_start && !i_stop) begin
               state_d = ST_SHIFT;
               word_d  = i_data;
               div_d   = sel_div_c;
               data_d  = pick_bit(i_data, '0);
            end
         end
         ST_SHIFT: begin
            last_bit_d = data_q;
            if (i_stop) begin
               state_d    = ST_IDLE;
               div_cnt_d  = '0;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               data_d     = idle_level(i_idle_mode, data_q);
            end else begin
               div_cnt_d = div_tick_c ? '0 : div_cnt_q + DIV_WIDTH'(1);
               if (div_tick_c) begin
                  tick_cnt_d = (tick_cnt_q == TICK_W'(TICK_PER_BIT - 1)) ? '0
                                                                         : tick_cnt_q + TICK_W'(1);
               end
               if (bit_end_c) begin
                  if (bit_cnt_q == BIT_W'(DATA_BIT - 1)) begin
                     bit_cnt_d = '0;
                     // Repeat mode reloads with no gap; other modes drop to the idle level.
                     if (i_idle_mode == 2'b11) begin
                        data_d = pick_bit(word_q, '0);
                     end else begin
                        state_d = ST_IDLE;
                        data_d  = idle_level(i_idle_mode, data_q);
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                     data_d    = pick_bit(word_q, bit_cnt_q + BIT_W'(1));
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_SHIFT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         div_q      <= '0;
         div_cnt_q  <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         last_bit_q <= 1'b0;
         data_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         div_q      <= div_d;
         div_cnt_q  <= div_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         last_bit_q <= last_bit_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_multi_freq_serial_out.sv
// Directed bench for multi_freq_serial_out: vector table of single frames plus corner-case sequences.
`timescale 1ns/1ps

module tb_multi_freq_serial_out;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] i_sel_freq;
   logic       i_start;
   logic       i_stop;
   logic [1:0] i_idle_mode;
   logic [7:0] i_data;
   logic       o_data;
   logic       o_busy;
   logic       o_done_tick;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multi_freq_serial_out #(
      .DATA_BIT(8), .TICK_PER_BIT(4), .DIV_WIDTH(8),
      .DIV0(4), .DIV1(2), .DIV2(3), .DIV3(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_sel_freq(i_sel_freq), .i_start(i_start),
      .i_stop(i_stop), .i_idle_mode(i_idle_mode), .i_data(i_data),
      .o_data(o_data), .o_busy(o_busy), .o_done_tick(o_done_tick)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] sel;
      logic [1:0] mode;
      int         cpb;       // expected clocks per bit
      logic       exp_idle;  // expected o_data after the frame
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected serial bit in cycle c (c=1 is the clock after start); wraps for repeated frames.
   function automatic logic exp_bit(input logic [7:0] d, input int cpb, input int c);
      logic [2:0] b3;
      b3 = 3'(((c - 1) / cpb) % 8);
`ifdef SERIAL_OUT_LSB_FIRST_EN
      return d[b3];
`else
      return d[3'd7 - b3];
`endif
   endfunction

   task automatic check_cycle(input string tag, input logic [7:0] d, input int cpb, input int c);
      int frame;
      frame = 8 * cpb;
      chk($sformatf("%s c%0d data", tag, c), o_data, exp_bit(d, cpb, c));
      chk($sformatf("%s c%0d busy", tag, c), o_busy, 1'b1);
      chk($sformatf("%s c%0d done", tag, c), o_done_tick, (c % frame) == 0);
   endtask

   task automatic start_frame(input logic [7:0] d, input logic [1:0] sel, input logic [1:0] mode);
      i_data      = d;
      i_sel_freq  = sel;
      i_idle_mode = mode;
      i_start     = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cpb;
      vecs[0] = '{8'hA5, 2'd0, 2'b00, 16, 1'b0};
      vecs[1] = '{8'hA5, 2'd1, 2'b01, 8, 1'b1};
`ifdef SERIAL_OUT_LSB_FIRST_EN
      vecs[2] = '{8'hA4, 2'd1, 2'b10, 8, 1'b1};
      vecs[3] = '{8'h3D, 2'd3, 2'b10, 4, 1'b0};
`else
      vecs[2] = '{8'hA4, 2'd1, 2'b10, 8, 1'b0};
      vecs[3] = '{8'h3D, 2'd3, 2'b10, 4, 1'b1};
`endif
      vecs[4] = '{8'hFF, 2'd2, 2'b00, 12, 1'b0};
      vecs[5] = '{8'h5A, 2'd3, 2'b01, 4, 1'b1};

      rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0;
      i_sel_freq = 2'd0; i_idle_mode = 2'b00; i_data = 8'h00;
      step(); step();
      chk("reset data", o_data, 1'b0);
      chk("reset busy", o_busy, 1'b0);
      chk("reset done", o_done_tick, 1'b0);
      rst_n = 1'b1;
      step();
      chk("post-reset busy", o_busy, 1'b0);

      // Single frames from the table
      foreach (vecs[i]) begin
         cpb = vecs[i].cpb;
         start_frame(vecs[i].data, vecs[i].sel, vecs[i].mode);
         for (int c = 1; c <= 8 * cpb; c++) begin
            check_cycle($sformatf("vec%0d", i), vecs[i].data, cpb, c);
            step();
         end
         chk($sformatf("vec%0d end busy", i), o_busy, 1'b0);
         chk($sformatf("vec%0d end data", i), o_data, vecs[i].exp_idle);
         chk($sformatf("vec%0d end done", i), o_done_tick, 1'b0);
         step();
         chk($sformatf("vec%0d idle data", i), o_data, vecs[i].exp_idle);
      end

      // Repeat mode: continuous frames, then abort mid-frame
      start_frame(8'h81, 2'd1, 2'b11);
      for (int c = 1; c <= 200; c++) begin
         check_cycle("rep", 8'h81, 8, c);
         if (c == 200) i_stop = 1'b1;
         step();
      end
      i_stop = 1'b0;
      chk("rep stop busy", o_busy, 1'b0);
      chk("rep stop data", o_data, 1'b0);
      for (int c = 0; c < 80; c++) begin
         chk($sformatf("rep idle done %0d", c), o_done_tick, 1'b0);
         chk($sformatf("rep idle busy %0d", c), o_busy, 1'b0);
         step();
      end

      // Stop coincident with frame end in repeat mode: no pulse, no repeat
      start_frame(8'hA5, 2'd0, 2'b11);
      for (int c = 1; c < 128; c++) begin
         check_cycle("sfe", 8'hA5, 16, c);
         step();
      end
      i_stop = 1'b1;
      #1;
      chk("sfe done suppressed", o_done_tick, 1'b0);
      step();
      i_stop = 1'b0;
      chk("sfe busy", o_busy, 1'b0);
      chk("sfe data", o_data, 1'b0);
      step();
      chk("sfe no repeat", o_busy, 1'b0);

      // Start and stop together in idle
      i_idle_mode = 2'b00;
      i_start = 1'b1; i_stop = 1'b1;
      step();
      i_start = 1'b0; i_stop = 1'b0;
      chk("ss busy", o_busy, 1'b0);
      step();
      chk("ss busy2", o_busy, 1'b0);

      // Start while busy with new data/rate is ignored
      start_frame(8'hA5, 2'd0, 2'b00);
      for (int c = 1; c <= 128; c++) begin
         check_cycle("ign", 8'hA5, 16, c);
         if (c == 10) begin
            i_start = 1'b1; i_data = 8'h00; i_sel_freq = 2'd1;
         end else begin
            i_start = 1'b0;
         end
         step();
      end
      chk("ign end busy", o_busy, 1'b0);
      chk("ign end data", o_data, 1'b0);

      // Idle level follows the mode live; last bit sent was 1
      i_idle_mode = 2'b10; step();
      chk("live mode10", o_data, 1'b1);
      i_idle_mode = 2'b01; step();
      chk("live mode01", o_data, 1'b1);
      i_idle_mode = 2'b11; step();
      chk("live mode11", o_data, 1'b0);
      i_idle_mode = 2'b00; step();
      chk("live mode00", o_data, 1'b0);
      i_idle_mode = 2'b10; step();
      chk("live mode10b", o_data, 1'b1);

      // Reset mid-frame
      start_frame(8'hFF, 2'd0, 2'b01);
      for (int c = 1; c < 50; c++) step();
      check_cycle("rst", 8'hFF, 16, 50);
      rst_n = 1'b0;
      i_idle_mode = 2'b10;
      #1;
      chk("midrst data", o_data, 1'b0);
      chk("midrst busy", o_busy, 1'b0);
      chk("midrst done", o_done_tick, 1'b0);
      step();
      rst_n = 1'b1;
      step(); step();
      chk("after rst busy", o_busy, 1'b0);
      chk("after rst lastbit cleared", o_data, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
